tx_cordic_upconverter: RTL and testbench

Transmit-path CORDIC upconverter: the mirror of the receive-side downconverter. It takes complex baseband I/Q samples from the TX interpolator, rotates them by a 32-bit NCO phase with a pipelined CORDIC, and delivers the real part as a rounded, saturated sample for the DAC. It sits between the TX CIC/interpolator output and the DAC output register and is clocked at the DAC sample rate.

---
 rtl/tx_cordic_upconverter.sv | 174 +++++++++++++++++
 tb/tb_tx_cordic_upconverter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tx_cordic_upconverter.sv
// Transmit CORDIC upconverter. The held baseband I/Q sample is rotated by the
// NCO phase through a pipelined rotation-mode CORDIC. The real part is rounded,
// saturated and registered as the DAC sample. The CORDIC gain is left in.
module tx_cordic_upconverter #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 12,
   parameter int STG       = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [31:0]          frequency,
   input  logic [IN_WIDTH-1:0]  in_i,
   input  logic [IN_WIDTH-1:0]  in_q,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid
);

   // Three guard bits cover the quadrant negation and the CORDIC growth
   // (K * sqrt(2) < 4).
   localparam int WR = IN_WIDTH + 3;
   localparam int WZ = STG + 2;
   localparam int SH = IN_WIDTH - OUT_WIDTH + 1;
   localparam int QW = WR - SH + 1;

   localparam logic signed [WR:0]    RHALF = (WR+1)'(2**(SH-1));
   localparam logic signed [QW-1:0]  QMAX  = QW'(2**(OUT_WIDTH-1) - 1);
   localparam logic signed [QW-1:0]  QMIN  = QW'(-(2**(OUT_WIDTH-1)));

   // atan(2^-n) scaled so that 2^32 is a full turn.
   function automatic logic [31:0] atan32(input int n);
      case (n)
         0:  atan32 = 32'd536870912;
         1:  atan32 = 32'd316933406;
         2:  atan32 = 32'd167458907;
         3:  atan32 = 32'd85004756;
         4:  atan32 = 32'd42667331;
         5:  atan32 = 32'd21354465;
         6:  atan32 = 32'd10679838;
         7:  atan32 = 32'd5340245;
         8:  atan32 = 32'd2670163;
         9:  atan32 = 32'd1335087;
         10: atan32 = 32'd667544;
         11: atan32 = 32'd333772;
         12: atan32 = 32'd166886;
         13: atan32 = 32'd83443;
         14: atan32 = 32'd41722;
         15: atan32 = 32'd20861;
         16: atan32 = 32'd10430;
         17: atan32 = 32'd5215;
         18: atan32 = 32'd2608;
         19: atan32 = 32'd1304;
         20: atan32 = 32'd652;
         21: atan32 = 32'd326;
         22: atan32 = 32'd163;
         23: atan32 = 32'd81;
         24: atan32 = 32'd41;
         25: atan32 = 32'd20;
         26: atan32 = 32'd10;
         27: atan32 = 32'd5;
         28: atan32 = 32'd3;
         29: atan32 = 32'd1;
         30: atan32 = 32'd1;
         default: atan32 = 32'd0;
      endcase
   endfunction

   // Stage angle rescaled to the WZ-bit angle register, rounded to nearest.
   function automatic logic [WZ-1:0] ang(input int n);
      logic [32:0] t;
      t   = {1'b0, atan32(n)} + (33'd1 << (31 - WZ));
      ang = WZ'(t >> (32 - WZ));
   endfunction

   logic [31:0]          phase;
   logic [IN_WIDTH-1:0]  hi, hq;
   logic signed [WR-1:0] ei, eq, x0, y0;
   logic signed [WR-1:0] x [0:STG];
   logic signed [WR-1:0] y [0:STG];
   logic [WZ-1:0]        z [0:STG];
   logic                 started;
   logic [STG+1:0]       vsr;
   logic signed [WR:0]   rnd;
   logic signed [QW-1:0] qv;
   logic [OUT_WIDTH-1:0] sat_val;

   // Zero-order hold of the baseband sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         hq <= '0;
      end else if (in_valid) begin
         hi <= in_i;
         hq <= in_q;
      end
   end

   // NCO accumulator. A zero increment restarts the phase at 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)            phase <= '0;
      else if (frequency == '0) phase <= '0;
      else                     phase <= phase + frequency;
   end

   assign ei = {{(WR-IN_WIDTH){hi[IN_WIDTH-1]}}, hi};
   assign eq = {{(WR-IN_WIDTH){hq[IN_WIDTH-1]}}, hq};

   // Coarse quadrant rotation that brings the residual angle into [0, pi/2).
   always_comb begin
      x0 = ei;
      y0 = eq;
      case (phase[31:30])
         2'd0: begin x0 = ei;  y0 = eq;  end
         2'd1: begin x0 = -eq; y0 = ei;  end
         2'd2: begin x0 = -ei; y0 = -eq; end
         default: begin x0 = eq; y0 = -ei; end
      endcase
   end

   // Stage-0 register followed by the STG micro-rotation stages.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n <= STG; n++) begin
            x[n] <= '0;
            y[n] <= '0;
            z[n] <= '0;
         end
      end else begin
         x[0] <= x0;
         y[0] <= y0;
         z[0] <= {2'b00, phase[29 -: WZ-2]};
         for (int n = 0; n < STG; n++) begin
            if (!z[n][WZ-1]) begin
               x[n+1] <= x[n] - (y[n] >>> n);
               y[n+1] <= y[n] + (x[n] >>> n);
               z[n+1] <= z[n] - ang(n);
            end else begin
               x[n+1] <= x[n] + (y[n] >>> n);
               y[n+1] <= y[n] - (x[n] >>> n);
               z[n+1] <= z[n] + ang(n);
            end
         end
      end
   end

   // Round half up on the dropped LSBs, then clamp to the DAC range.
   always_comb begin
      rnd = {x[STG][WR-1], x[STG]} + RHALF;
      qv  = rnd[WR:SH];
      if (qv > QMAX)      sat_val = QMAX[OUT_WIDTH-1:0];
      else if (qv < QMIN) sat_val = QMIN[OUT_WIDTH-1:0];
      else                sat_val = qv[OUT_WIDTH-1:0];
   end

   // Registered DAC sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) out_data <= '0;
      else          out_data <= sat_val;
   end

   // Sticky first-sample flag, delayed to line up with the data path.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         started <= 1'b0;
         vsr     <= '0;
      end else begin
         started <= started | in_valid;
         vsr     <= {vsr[STG:0], started};
      end
   end

   assign out_valid = vsr[STG+1];

endmodule

// File: tb/tb_tx_cordic_upconverter.sv
// Bench for tx_cordic_upconverter: the driver advances a floating-point model
// (ideal rotation times CORDIC gain) and queues the expected DAC samples; a
// negedge monitor compares them against the DUT.
module tb_tx_cordic_upconverter;

   localparam int IW  = 16;
   localparam int OW  = 12;
   localparam int STG = 16;
   localparam real PI = 3.14159265358979323846;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [31:0]   frequency;
   logic [IW-1:0] in_i, in_q;
   logic          in_valid;
   logic [OW-1:0] out_data;
   logic          out_valid;

   tx_cordic_upconverter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .STG(STG)) dut (
      .clock(clock), .reset_n(reset_n), .frequency(frequency),
      .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   real         kgain;
   logic [31:0] m_phase;
   int          m_hi, m_hq, m_cnt;
   bit          m_started, m_valid;
   int          exp_q[$];

   task automatic chk(input string name, input int act, input int exp, input int tol);
      int d;
      n_chk++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
      end
   endtask

   function automatic int ref_out(input int i, input int q, input logic [31:0] ph);
      real th, xv;
      int  o;
      th = 2.0 * PI * real'(ph) / 4294967296.0;
      xv = kgain * (real'(i) * $cos(th) - real'(q) * $sin(th));
      o  = $rtoi($floor(xv / 32.0 + 0.5));
      if (o > 2047)  o = 2047;
      if (o < -2048) o = -2048;
      return o;
   endfunction

   task automatic model_reset();
      m_phase = '0; m_hi = 0; m_hq = 0; m_cnt = 0;
      m_started = 0; m_valid = 0;
      exp_q.delete();
   endtask

   // Effect of one rising edge on the model.
   task automatic model_step(input logic [31:0] f, input int i, input int q, input logic v);
      if (!reset_n) return;
      if (m_started) exp_q.push_back(ref_out(m_hi, m_hq, m_phase));
      m_phase = (f == 0) ? 32'd0 : m_phase + f;
      if (v) begin m_hi = i; m_hq = q; end
      if (m_started) m_cnt++;
      else if (v) begin m_started = 1; m_cnt = 0; end
      m_valid = m_started && (m_cnt >= STG + 2);
   endtask

   task automatic step(input logic [31:0] f, input int i, input int q, input logic v);
      frequency = f; in_i = 16'(i); in_q = 16'(q); in_valid = v;
      @(posedge clock);
      model_step(f, i, q, v);
      #1;
   endtask

   function automatic int rnd_s16();
      return int'($urandom_range(0, 65534)) - 32767;
   endfunction

   function automatic int dac();
      return int'($signed(out_data));
   endfunction

   // Monitor: valid flag every cycle, data against the scoreboard when valid.
   always @(negedge clock) begin
      chk("out_valid", int'(out_valid), int'(m_valid), 0);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: got sample %0d, expected none queued at %0t", dac(), $time);
         end else begin
            chk("out_data", dac(), exp_q.pop_front(), 2);
         end
      end else begin
         chk("idle_data", dac(), 0, 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit 2000000 expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pat[4];
      int s17, s18;
      logic [31:0] f;
      kgain = 1.0;
      for (int n = 0; n < STG; n++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * n));
      model_reset();

      // reset with random inputs
      reset_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         frequency = $urandom; in_i = 16'($urandom); in_q = 16'($urandom);
         in_valid = 1'($urandom);
         @(posedge clock); #1;
         chk("reset_data", dac(), 0, 0);
         chk("reset_valid", int'(out_valid), 0, 0);
      end
      reset_n = 1'b1;

      // idle cycles before the first accepted sample
      repeat (3) step(32'd0, rnd_s16(), rnd_s16(), 1'b0);

      // DC along Q, then along I, at zero frequency
      repeat (25) step(32'd0, 0, 16384, 1'b1);
      chk("dc_q", dac(), 0, 1);
      repeat (25) step(32'd0, 16384, 0, 1'b1);
      chk("dc_i", dac(), 843, 1);

      // fs/4 carrier from a fresh phase restart
      pat[0] = 843; pat[1] = 0; pat[2] = -843; pat[3] = 0;
      for (int t = 0; t < 24; t++) begin
         step(32'h4000_0000, 16384, 0, 1'b1);
         if (t >= 18) chk("fs4_pattern", dac(), pat[(t - 17) % 4], 1);
      end

      // saturation: zero-frequency full scale, then fs/8 peaks in both signs
      repeat (25) step(32'd0, 32767, -32767, 1'b1);
      repeat (25) step(32'd0, -32767, 32767, 1'b1);
      repeat (25) step(32'd0, 32767, -32767, 1'b1);
      for (int t = 0; t < 24; t++) begin
         step(32'h2000_0000, 32767, -32767, 1'b1);
         if (t == 18) chk("sat_pos", dac(), 2047, 0);
         if (t == 22) chk("sat_neg", dac(), -2048, 0);
      end

      // hold: inputs wiggle with in_valid low, output must not move
      repeat (25) step(32'd0, -16384, 0, 1'b1);
      for (int t = 0; t < 10; t++) begin
         step(32'd0, rnd_s16(), rnd_s16(), 1'b0);
         chk("hold_const", dac(), -843, 1);
      end
      step(32'd0, 16384, 0, 1'b1);
      for (int t = 1; t <= 20; t++) begin
         step(32'd0, rnd_s16(), rnd_s16(), 1'b0);
         if (t == 17) s17 = dac();
         if (t == 18) s18 = dac();
      end
      chk("hold_before_edge18", s17, -843, 1);
      chk("hold_at_edge18", s18, 843, 1);

      // random frequencies, samples and strobes
      f = $urandom;
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 39) == 0) f = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         step(f, rnd_s16(), rnd_s16(), 1'($urandom_range(0, 1)));
      end

      // one-cycle reset pulse mid-stream
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset_valid", int'(out_valid), 0, 0);
      chk("midreset_data", dac(), 0, 0);
      model_reset();
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 39) == 0) f = $urandom;
         step(f, rnd_s16(), rnd_s16(), 1'($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
